// File: rtl/fetch_ctrl.sv
// Fetch-address generator and icache request sequencer.
// Holds the current fetch PC, keeps at most one icache request outstanding,
// pushes two-instruction groups into the instruction buffer on each response,
// and handles flush redirects, stall replay, buffer backpressure and
// misaligned fetch addresses (ADEF).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [31:0]      new_pc,
  input  logic             stall,
  input  logic             buffer_full,
  output logic             fetch_req,
  output logic [31:0]      fetch_addr,
  input  logic             fetch_ack,
  input  logic             resp_valid,
  input  logic [1:0]       pre_taken_or_not,
  input  logic [31:0]      pre_branch_addr,
  output logic [1:0]       icache_fetch_inst_en,
  output logic [1:0][31:0] pc,
  output logic             adef
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] cur_pc;
  logic [31:0] pc_next;
  logic        err_done;
  logic        err_report;
  logic        taken;
  logic [31:0] seq_pc;

  // Slot0 has priority: any taken slot redirects to the single predicted target.
  assign taken  = |pre_taken_or_not;
  assign seq_pc = cur_pc + 32'd8;

  // Fetch group base and per-slot PCs always reflect the current fetch PC.
  assign fetch_addr = cur_pc;
  assign pc[0]      = cur_pc;
  assign pc[1]      = cur_pc + 32'd4;

  // Next-state, next-PC and output decode; flush overrides every state.
  always_comb begin
    state_next           = state;
    pc_next              = cur_pc;
    fetch_req            = 1'b0;
    icache_fetch_inst_en = 2'b00;
    adef                 = 1'b0;
    err_report           = 1'b0;

    if (flush) begin
      pc_next = new_pc;
      // A request still in flight leaves a stale response to swallow.
      if ((state == WAIT || state == DISCARD) && !resp_valid) begin
        state_next = DISCARD;
      end else begin
        state_next = REQ;
      end
    end else begin
      case (state)
        REQ: begin
          if (cur_pc[1:0] != 2'b00) begin
            state_next = ERR;
          end else begin
            // rst_n gate keeps the request low while reset is held.
            fetch_req = rst_n && !stall && !buffer_full;
            if (fetch_req && fetch_ack) begin
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          if (resp_valid) begin
            state_next = REQ;
            // A stalled response is dropped and the same group is refetched.
            if (!stall) begin
              icache_fetch_inst_en = 2'b11;
              pc_next              = taken ? pre_branch_addr : seq_pc;
            end
          end
        end
        DISCARD: begin
          if (resp_valid) begin
            state_next = REQ;
          end
        end
        ERR: begin
          // Report the faulting address once, then idle until redirected.
          if (!err_done && !stall && !buffer_full) begin
            icache_fetch_inst_en = 2'b01;
            adef                 = 1'b1;
            err_report           = 1'b1;
          end
        end
        default: begin
          state_next = REQ;
        end
      endcase
    end
  end

  // State, fetch PC and one-shot ADEF report flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      cur_pc   <= RESET_PC;
      err_done <= 1'b0;
    end else begin
      state  <= state_next;
      cur_pc <= pc_next;
      if (flush || state != ERR) begin
        err_done <= 1'b0;
      end else if (err_report) begin
        err_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scripted icache handshakes with a
// scoreboard of expected buffer pushes compared on the falling edge.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [31:0]      new_pc = '0;
  logic             stall = 1'b0;
  logic             buffer_full = 1'b0;
  logic             fetch_req;
  logic [31:0]      fetch_addr;
  logic             fetch_ack = 1'b0;
  logic             resp_valid = 1'b0;
  logic [1:0]       pre_taken_or_not = 2'b00;
  logic [31:0]      pre_branch_addr = '0;
  logic [1:0]       icache_fetch_inst_en;
  logic [1:0][31:0] pc;
  logic             adef;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  en;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        adef;
  } push_t;

  push_t       sb[$];
  push_t       exp_p;
  logic [31:0] model_pc;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush                (flush),
    .new_pc               (new_pc),
    .stall                (stall),
    .buffer_full          (buffer_full),
    .fetch_req            (fetch_req),
    .fetch_addr           (fetch_addr),
    .fetch_ack            (fetch_ack),
    .resp_valid           (resp_valid),
    .pre_taken_or_not     (pre_taken_or_not),
    .pre_branch_addr      (pre_branch_addr),
    .icache_fetch_inst_en (icache_fetch_inst_en),
    .pc                   (pc),
    .adef                 (adef)
  );

  always #5 clk = ~clk;

  // Scoreboard: every push seen by the buffer must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && icache_fetch_inst_en != 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push en=%b pc0=%h pc1=%h adef=%b", icache_fetch_inst_en, pc[0], pc[1], adef);
      end else begin
        exp_p = sb.pop_front();
        if (icache_fetch_inst_en !== exp_p.en || pc[0] !== exp_p.pc0 || pc[1] !== exp_p.pc1 || adef !== exp_p.adef) begin
          errors++;
          $display("FAIL push got en=%b pc0=%h pc1=%h adef=%b expected en=%b pc0=%h pc1=%h adef=%b",
                   icache_fetch_inst_en, pc[0], pc[1], adef, exp_p.en, exp_p.pc0, exp_p.pc1, exp_p.adef);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a request for addr in the current cycle, then acknowledge it.
  task automatic do_req(input logic [31:0] addr, input string name);
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== addr) begin
      errors++;
      $display("FAIL %s req=%b addr=%h expected req=1 addr=%h", name, fetch_req, fetch_addr, addr);
    end
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
  endtask

  // Drive one icache response; queue the expected push when one should occur.
  task automatic do_resp(input logic [1:0] tk, input logic [31:0] tgt, input logic [31:0] grp,
                         input bit push, input string name);
    resp_valid       = 1'b1;
    pre_taken_or_not = tk;
    pre_branch_addr  = tgt;
    if (push) sb.push_back('{2'b11, grp, grp + 32'd4, 1'b0});
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_during_resp got=%b expected=0", name, fetch_req);
    end
    if (!push) begin
      checks++;
      if (icache_fetch_inst_en !== 2'b00) begin
        errors++;
        $display("FAIL %s_no_push en=%b expected=00", name, icache_fetch_inst_en);
      end
    end
    tick();
    resp_valid       = 1'b0;
    pre_taken_or_not = 2'b00;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0 || icache_fetch_inst_en !== 2'b00 || adef !== 1'b0) begin
      errors++;
      $display("FAIL %s req=%b en=%b adef=%b expected 0/00/0", name, fetch_req, icache_fetch_inst_en, adef);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b expected=0", fetch_req); end
    checks++;
    if (icache_fetch_inst_en !== 2'b00) begin errors++; $display("FAIL reset_en got=%b expected=00", icache_fetch_inst_en); end
    checks++;
    if (adef !== 1'b0) begin errors++; $display("FAIL reset_adef got=%b expected=0", adef); end
    checks++;
    if (fetch_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h expected=%h", fetch_addr, RESET_PC); end
    checks++;
    if (pc[0] !== RESET_PC || pc[1] !== RESET_PC + 32'd4) begin
      errors++;
      $display("FAIL reset_pc got=%h/%h expected=%h/%h", pc[0], pc[1], RESET_PC, RESET_PC + 32'd4);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    do_req(32'h1c00_0000, "seq0");
    do_resp(2'b00, 32'h0, 32'h1c00_0000, 1, "seq0");
    do_req(32'h1c00_0008, "seq1");
    do_resp(2'b00, 32'h0, 32'h1c00_0008, 1, "seq1");
  endtask

  task automatic test_taken();
    do_req(32'h1c00_0010, "taken_slot0_req");
    do_resp(2'b01, 32'h1c00_0100, 32'h1c00_0010, 1, "taken_slot0");
    do_req(32'h1c00_0100, "taken_slot0_target");
    do_resp(2'b10, 32'h1c00_0100, 32'h1c00_0100, 1, "taken_slot1");
  endtask

  task automatic test_stall();
    do_req(32'h1c00_0100, "taken_slot1_target");
    stall = 1'b1;
    do_resp(2'b00, 32'h0, 32'h1c00_0100, 0, "stall_resp");
    check_idle("stall_hold0");
    check_idle("stall_hold1");
    stall = 1'b0;
    do_req(32'h1c00_0100, "stall_replay");
    do_resp(2'b00, 32'h0, 32'h1c00_0100, 1, "stall_replay");
  endtask

  task automatic test_flush_wait();
    do_req(32'h1c00_0108, "flush_pre");
    flush  = 1'b1;
    new_pc = 32'h1c00_0200;
    check_idle("flush_wait_cycle");
    flush = 1'b0;
    check_idle("discard0");
    check_idle("discard1");
    do_resp(2'b01, 32'h1c00_0400, 32'h0, 0, "stale_resp");
    do_req(32'h1c00_0200, "flush_target");
    flush  = 1'b1;
    new_pc = 32'h1c00_0200;
    do_resp(2'b00, 32'h0, 32'h0, 0, "flush_with_resp");
    flush = 1'b0;
    do_req(32'h1c00_0200, "flush_resp_target");
    do_resp(2'b00, 32'h0, 32'h1c00_0200, 1, "flush_resp_target");
  endtask

  task automatic test_backpressure();
    buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) check_idle("buffer_full_hold");
    buffer_full = 1'b0;
    do_req(32'h1c00_0208, "buffer_full_resume");
    buffer_full = 1'b1;
    do_resp(2'b00, 32'h0, 32'h1c00_0208, 1, "inflight_push_when_full");
    buffer_full = 1'b0;
  endtask

  task automatic test_adef();
    flush  = 1'b1;
    new_pc = 32'h1c00_0002;
    check_idle("adef_flush");
    flush = 1'b0;
    check_idle("adef_req_blocked");
    sb.push_back('{2'b01, 32'h1c00_0002, 32'h1c00_0006, 1'b1});
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin errors++; $display("FAIL adef_report_req got=%b expected=0", fetch_req); end
    tick();
    for (int i = 0; i < 3; i++) check_idle("adef_idle");
    flush  = 1'b1;
    new_pc = 32'h1c00_0300;
    check_idle("adef_exit_flush");
    flush = 1'b0;
    do_req(32'h1c00_0300, "adef_resume");
    do_resp(2'b00, 32'h0, 32'h1c00_0300, 1, "adef_resume");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  tk;
    logic [31:0] tgt;
    model_pc = 32'h1c00_0308;
    for (int i = 0; i < 6; i++) begin
      tk  = 2'($urandom_range(0, 3));
      tgt = 32'h1c00_0000 | (32'($urandom_range(0, 255)) << 3);
      do_req(model_pc, "b2b");
      do_resp(tk, tgt, model_pc, 1, "b2b");
      model_pc = (tk != 2'b00) ? tgt : model_pc + 32'd8;
    end
    flush  = 1'b1;
    new_pc = 32'hffff_fff8;
    check_idle("wrap_flush");
    flush = 1'b0;
    do_req(32'hffff_fff8, "wrap_pre");
    do_resp(2'b00, 32'h0, 32'hffff_fff8, 1, "wrap_pre");
    do_req(32'h0000_0000, "wrap_post");
    do_resp(2'b00, 32'h0, 32'h0000_0000, 1, "wrap_post");
  endtask

  task automatic test_async_reset();
    do_req(32'h0000_0008, "arst_pre");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_req !== 1'b0 || fetch_addr !== RESET_PC) begin
      errors++;
      $display("FAIL async_reset req=%b addr=%h expected 0/%h", fetch_req, fetch_addr, RESET_PC);
    end
    tick();
    rst_n      = 1'b1;
    resp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (icache_fetch_inst_en !== 2'b00) begin
      errors++;
      $display("FAIL late_resp_after_reset en=%b expected=00", icache_fetch_inst_en);
    end
    tick();
    resp_valid = 1'b0;
    do_req(RESET_PC, "arst_restart");
    do_resp(2'b00, 32'h0, RESET_PC, 1, "arst_restart");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken();
    test_stall();
    test_flush_wait();
    test_backpressure();
    test_adef();
    test_back_to_back();
    test_async_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pushes got=%0d outstanding expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
